// File: rtl/aram_sched.sv
// Shared audio RAM slot scheduler: fixed 4-slot rotation (SMP, DSP, DSP, loader), one access per slot.
// Slow memory stretches the current slot instead of dropping or corrupting the access.
module aram_sched #(
  parameter int SLOT_CYCLES = 4,
  parameter int STALL_W     = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [15:0]        SMP_A,
  input  logic [7:0]         SMP_DO,
  input  logic               SMP_WE_N,
  output logic [7:0]         SMP_DI,
  output logic               SMP_EN,
  input  logic               DSP_REQ,
  input  logic [15:0]        DSP_A,
  input  logic [7:0]         DSP_DO,
  input  logic               DSP_WE_N,
  output logic [7:0]         DSP_DI,
  output logic               DSP_ACK,
  input  logic               LD_HOLD,
  input  logic               LD_REQ,
  input  logic [15:0]        LD_A,
  input  logic [7:0]         LD_DO,
  input  logic               LD_WE_N,
  output logic [7:0]         LD_DI,
  output logic               LD_ACK,
  output logic               MEM_REQ,
  output logic [15:0]        MEM_A,
  output logic [7:0]         MEM_DO,
  output logic               MEM_WE_N,
  input  logic [7:0]         MEM_RDATA,
  input  logic               MEM_ACK,
  output logic [1:0]         SLOT,
  output logic [STALL_W-1:0] STALL_CNT
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST    = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {START, WAIT, PAD} state_t;
  typedef enum logic [1:0] {OWN_SMP, OWN_DSP, OWN_LD} owner_t;

  state_t        state, state_nxt;
  owner_t        owner, own_sel;
  logic [CW-1:0] cnt;
  logic          has_req;
  logic [15:0]   sel_a;
  logic [7:0]    sel_do;
  logic          sel_we_n;
  logic          acked;

  // A stray MEM_ACK outside an active request never completes anything.
  assign acked = MEM_REQ & MEM_ACK;

  always_comb begin
    own_sel  = OWN_LD;
    has_req  = LD_REQ;
    sel_a    = LD_A;
    sel_do   = LD_DO;
    sel_we_n = LD_WE_N;
    if (!LD_HOLD) begin
      case (SLOT)
        2'd0:       own_sel = OWN_SMP;
        2'd1, 2'd2: own_sel = OWN_DSP;
        default:    own_sel = OWN_LD;
      endcase
    end
    case (own_sel)
      OWN_SMP: begin
        has_req  = 1'b1;
        sel_a    = SMP_A;
        sel_do   = SMP_DO;
        sel_we_n = SMP_WE_N;
      end
      OWN_DSP: begin
        has_req  = DSP_REQ;
        sel_a    = DSP_A;
        sel_do   = DSP_DO;
        sel_we_n = DSP_WE_N;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      START:   state_nxt = has_req ? WAIT : PAD;
      WAIT:    if (acked) state_nxt = PAD;
      PAD:     if (cnt == LAST) state_nxt = START;
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= START;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt       <= '0;
      SLOT      <= 2'd0;
      owner     <= OWN_SMP;
      MEM_REQ   <= 1'b0;
      MEM_A     <= 16'h0000;
      MEM_DO    <= 8'h00;
      MEM_WE_N  <= 1'b1;
      SMP_DI    <= 8'h00;
      DSP_DI    <= 8'h00;
      LD_DI     <= 8'h00;
      SMP_EN    <= 1'b0;
      DSP_ACK   <= 1'b0;
      LD_ACK    <= 1'b0;
      STALL_CNT <= '0;
    end else begin
      SMP_EN  <= 1'b0;
      DSP_ACK <= 1'b0;
      LD_ACK  <= 1'b0;
      case (state)
        START: begin
          cnt   <= cnt + CNT_ONE;
          owner <= own_sel;
          if (has_req) begin
            MEM_REQ  <= 1'b1;
            MEM_A    <= sel_a;
            MEM_DO   <= sel_do;
            MEM_WE_N <= sel_we_n;
          end
        end
        WAIT: begin
          // The counter parks on the last slot cycle until memory completes.
          if (cnt != LAST) cnt <= cnt + CNT_ONE;
          if (acked) begin
            MEM_REQ <= 1'b0;
            case (owner)
              OWN_SMP: begin SMP_DI <= MEM_RDATA; SMP_EN  <= 1'b1; end
              OWN_DSP: begin DSP_DI <= MEM_RDATA; DSP_ACK <= 1'b1; end
              default: begin LD_DI  <= MEM_RDATA; LD_ACK  <= 1'b1; end
            endcase
          end else if (cnt == LAST && STALL_CNT != {STALL_W{1'b1}}) begin
            STALL_CNT <= STALL_CNT + STALL_W'(1);
          end
        end
        default: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            SLOT <= SLOT + 2'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aram_sched.sv
// Directed bench for aram_sched: rotation, SMP read/hold, DSP back-to-back, stretch, loader hold, mid-access reset.
module tb_aram_sched;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] SMP_A;
  logic [7:0]  SMP_DO;
  logic        SMP_WE_N;
  logic [7:0]  SMP_DI;
  logic        SMP_EN;
  logic        DSP_REQ;
  logic [15:0] DSP_A;
  logic [7:0]  DSP_DO;
  logic        DSP_WE_N;
  logic [7:0]  DSP_DI;
  logic        DSP_ACK;
  logic        LD_HOLD;
  logic        LD_REQ;
  logic [15:0] LD_A;
  logic [7:0]  LD_DO;
  logic        LD_WE_N;
  logic [7:0]  LD_DI;
  logic        LD_ACK;
  logic        MEM_REQ;
  logic [15:0] MEM_A;
  logic [7:0]  MEM_DO;
  logic        MEM_WE_N;
  logic [7:0]  MEM_RDATA = 8'h00;
  logic        MEM_ACK = 1'b0;
  logic [1:0]  SLOT;
  logic [15:0] STALL_CNT;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  mem [0:65535];
  int          lat = 2;
  int          age = 0;
  logic [15:0] req_a = 16'h0000;
  logic        req_we = 1'b1;

  always #5 CLK = ~CLK;

  aram_sched #(.SLOT_CYCLES(4), .STALL_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .SMP_A(SMP_A), .SMP_DO(SMP_DO), .SMP_WE_N(SMP_WE_N), .SMP_DI(SMP_DI), .SMP_EN(SMP_EN),
    .DSP_REQ(DSP_REQ), .DSP_A(DSP_A), .DSP_DO(DSP_DO), .DSP_WE_N(DSP_WE_N),
    .DSP_DI(DSP_DI), .DSP_ACK(DSP_ACK),
    .LD_HOLD(LD_HOLD), .LD_REQ(LD_REQ), .LD_A(LD_A), .LD_DO(LD_DO), .LD_WE_N(LD_WE_N),
    .LD_DI(LD_DI), .LD_ACK(LD_ACK),
    .MEM_REQ(MEM_REQ), .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_WE_N(MEM_WE_N),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .SLOT(SLOT), .STALL_CNT(STALL_CNT)
  );

  // Memory: ACK is high in the lat-th cycle of REQ being high; a dropped REQ restarts the count.
  always @(posedge CLK) begin
    #1;
    if (MEM_REQ === 1'b1) begin
      age = age + 1;
      if (age == 1) begin
        req_a  = MEM_A;
        req_we = MEM_WE_N;
      end
      if (age == lat) begin
        MEM_ACK   = 1'b1;
        MEM_RDATA = mem[MEM_A];
        if (MEM_WE_N === 1'b0) mem[MEM_A] = MEM_DO;
      end else begin
        MEM_ACK = 1'b0;
      end
    end else begin
      age     = 0;
      MEM_ACK = 1'b0;
    end
  end

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_chk++;
    if ({MEM_REQ, MEM_WE_N, SMP_EN, DSP_ACK, LD_ACK} !== 5'b01000)
      $display("FAIL reset_ctl: got %b want 01000", {MEM_REQ, MEM_WE_N, SMP_EN, DSP_ACK, LD_ACK});
    else n_pass++;
    n_chk++;
    if ({MEM_A, MEM_DO} !== 24'h0)
      $display("FAIL reset_mem_bus: got %h want 000000", {MEM_A, MEM_DO});
    else n_pass++;
    n_chk++;
    if ({SMP_DI, DSP_DI, LD_DI} !== 24'h0)
      $display("FAIL reset_di: got %h want 000000", {SMP_DI, DSP_DI, LD_DI});
    else n_pass++;
    n_chk++;
    if (SLOT !== 2'd0) $display("FAIL reset_slot: got %0d want 0", SLOT);
    else n_pass++;
    n_chk++;
    if (STALL_CNT !== 16'd0) $display("FAIL reset_stall: got %0d want 0", STALL_CNT);
    else n_pass++;
    RST_N = 1'b1;
  endtask

  task automatic test_rotation();
    int   en_err = 0;
    int   slot_err = 0;
    int   en_cnt = 0;
    logic exp_en;
    logic [1:0] exp_slot;
    for (int k = 0; k < 64; k++) begin
      exp_en   = (k % 16 == 3);
      exp_slot = 2'((k / 4) % 4);
      if (SMP_EN !== exp_en) en_err++;
      if (SLOT !== exp_slot) slot_err++;
      if (SMP_EN === 1'b1) en_cnt++;
      @(negedge CLK);
    end
    n_chk++;
    if (en_err != 0) $display("FAIL rot_en_timing: got %0d misplaced cycles want 0", en_err);
    else n_pass++;
    n_chk++;
    if (slot_err != 0) $display("FAIL rot_slot_seq: got %0d wrong cycles want 0", slot_err);
    else n_pass++;
    n_chk++;
    if (en_cnt != 4) $display("FAIL rot_en_count: got %0d want 4", en_cnt);
    else n_pass++;
    n_chk++;
    if (STALL_CNT !== 16'd0) $display("FAIL rot_stall: got %0d want 0", STALL_CNT);
    else n_pass++;
  endtask

  task automatic test_smp_read();
    int t = 0;
    int gap = 0;
    int hold_err = 0;
    SMP_A    = 16'h1234;
    SMP_WE_N = 1'b1;
    while (SMP_EN !== 1'b1 && t < 40) begin @(negedge CLK); t++; end
    n_chk++;
    if (t != 3) $display("FAIL smp_en_delay: got %0d want 3", t);
    else n_pass++;
    n_chk++;
    if (req_a !== 16'h1234) $display("FAIL smp_mem_a: got %h want 1234", req_a);
    else n_pass++;
    n_chk++;
    if (req_we !== 1'b1) $display("FAIL smp_mem_we_n: got %b want 1", req_we);
    else n_pass++;
    n_chk++;
    if (SMP_DI !== 8'hA5) $display("FAIL smp_di: got %h want a5", SMP_DI);
    else n_pass++;
    SMP_A = 16'h1235;
    do begin
      @(negedge CLK);
      gap++;
      if (SMP_EN !== 1'b1 && SMP_DI !== 8'hA5) hold_err++;
    end while (SMP_EN !== 1'b1 && gap < 40);
    n_chk++;
    if (hold_err != 0) $display("FAIL smp_di_hold: got %0d changed cycles want 0", hold_err);
    else n_pass++;
    n_chk++;
    if (gap != 16) $display("FAIL smp_en_gap: got %0d want 16", gap);
    else n_pass++;
    n_chk++;
    if (SMP_DI !== 8'h77) $display("FAIL smp_di_next: got %h want 77", SMP_DI);
    else n_pass++;
  endtask

  task automatic test_dsp_back_to_back();
    int t = 0;
    int extra = 0;
    DSP_REQ  = 1'b1;
    DSP_A    = 16'h2000;
    DSP_DO   = 8'h5A;
    DSP_WE_N = 1'b0;
    while (DSP_ACK !== 1'b1 && t < 40) begin @(negedge CLK); t++; end
    n_chk++;
    if (t != 4 || SLOT !== 2'd1) $display("FAIL dsp_ack1: got delay %0d slot %0d want 4 slot 1", t, SLOT);
    else n_pass++;
    n_chk++;
    if (req_a !== 16'h2000 || req_we !== 1'b0)
      $display("FAIL dsp_wr_bus: got a=%h we_n=%b want 2000 0", req_a, req_we);
    else n_pass++;
    n_chk++;
    if (mem[16'h2000] !== 8'h5A) $display("FAIL dsp_wr_data: got %h want 5a", mem[16'h2000]);
    else n_pass++;
    DSP_A    = 16'h2001;
    DSP_WE_N = 1'b1;
    t = 0;
    do begin @(negedge CLK); t++; end while (DSP_ACK !== 1'b1 && t < 40);
    n_chk++;
    if (t != 4 || SLOT !== 2'd2) $display("FAIL dsp_ack2: got delay %0d slot %0d want 4 slot 2", t, SLOT);
    else n_pass++;
    n_chk++;
    if (req_a !== 16'h2001 || req_we !== 1'b1)
      $display("FAIL dsp_rd_bus: got a=%h we_n=%b want 2001 1", req_a, req_we);
    else n_pass++;
    n_chk++;
    if (DSP_DI !== 8'hC3) $display("FAIL dsp_di: got %h want c3", DSP_DI);
    else n_pass++;
    DSP_REQ = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (DSP_ACK === 1'b1) extra++;
    end
    n_chk++;
    if (extra != 0) $display("FAIL dsp_no_extra: got %0d acks want 0", extra);
    else n_pass++;
  endtask

  task automatic test_stall();
    int t = 0;
    int r = 0;
    while (SMP_EN !== 1'b1 && t < 40) begin @(negedge CLK); t++; end
    lat = 6;
    t = 0;
    do begin @(negedge CLK); t++; end while (MEM_REQ !== 1'b1 && t < 40);
    while (SMP_EN !== 1'b1 && r < 40) begin @(negedge CLK); r++; end
    lat = 2;
    n_chk++;
    if (r != 6) $display("FAIL stall_en_delay: got %0d want 6", r);
    else n_pass++;
    n_chk++;
    if (t + r != 20) $display("FAIL stall_en_gap: got %0d want 20", t + r);
    else n_pass++;
    n_chk++;
    if (STALL_CNT !== 16'd3) $display("FAIL stall_cnt: got %0d want 3", STALL_CNT);
    else n_pass++;
    n_chk++;
    if (SLOT !== 2'd0) $display("FAIL stall_slot_hold: got %0d want 0", SLOT);
    else n_pass++;
    @(negedge CLK);
    n_chk++;
    if (SLOT !== 2'd1) $display("FAIL stall_next_slot: got %0d want 1", SLOT);
    else n_pass++;
  endtask

  task automatic test_loader_hold();
    int t = 0;
    int acks = 0;
    int since = 0;
    int cyc = 0;
    int gap_err = 0;
    int en_seen = 0;
    int wr_err = 0;
    while (SMP_EN !== 1'b1 && t < 40) begin @(negedge CLK); t++; end
    LD_HOLD = 1'b1;
    LD_REQ  = 1'b1;
    LD_A    = 16'h0200;
    LD_DO   = 8'h00;
    LD_WE_N = 1'b0;
    while (acks < 8 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      since++;
      if (SMP_EN === 1'b1) en_seen++;
      if (LD_ACK === 1'b1) begin
        if (since != 4) gap_err++;
        since = 0;
        acks++;
        LD_A  = 16'(16'h0200 + acks);
        LD_DO = 8'(acks);
        if (acks == 8) begin
          LD_REQ  = 1'b0;
          LD_HOLD = 1'b0;
        end
      end
    end
    for (int i = 0; i < 8; i++)
      if (mem[16'h0200 + i] !== 8'(i)) wr_err++;
    n_chk++;
    if (acks != 8) $display("FAIL ld_ack_count: got %0d want 8", acks);
    else n_pass++;
    n_chk++;
    if (gap_err != 0) $display("FAIL ld_ack_spacing: got %0d bad gaps want 0", gap_err);
    else n_pass++;
    n_chk++;
    if (en_seen != 0) $display("FAIL ld_smp_frozen: got %0d smp_en want 0", en_seen);
    else n_pass++;
    n_chk++;
    if (wr_err != 0) $display("FAIL ld_writes: got %0d wrong bytes want 0", wr_err);
    else n_pass++;
    t = 0;
    do begin @(negedge CLK); t++; end while (SMP_EN !== 1'b1 && t < 40);
    n_chk++;
    if (t != 16) $display("FAIL ld_smp_resume: got %0d want 16", t);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t = 0;
    do begin @(negedge CLK); t++; end while (MEM_REQ !== 1'b1 && t < 40);
    RST_N = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (MEM_REQ !== 1'b0) $display("FAIL rstmid_req: got %b want 0", MEM_REQ);
    else n_pass++;
    n_chk++;
    if (SLOT !== 2'd0) $display("FAIL rstmid_slot: got %0d want 0", SLOT);
    else n_pass++;
    n_chk++;
    if ({SMP_EN, DSP_ACK, LD_ACK} !== 3'b000)
      $display("FAIL rstmid_acks: got %b want 000", {SMP_EN, DSP_ACK, LD_ACK});
    else n_pass++;
    n_chk++;
    if (STALL_CNT !== 16'd0) $display("FAIL rstmid_stall: got %0d want 0", STALL_CNT);
    else n_pass++;
    RST_N = 1'b1;
    t = 0;
    while (SMP_EN !== 1'b1 && t < 40) begin @(negedge CLK); t++; end
    n_chk++;
    if (t != 3) $display("FAIL rstmid_first_en: got %0d want 3", t);
    else n_pass++;
    t = 0;
    do begin @(negedge CLK); t++; end while (SMP_EN !== 1'b1 && t < 40);
    n_chk++;
    if (t != 16) $display("FAIL rstmid_en_gap: got %0d want 16", t);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8));
    mem[16'h1234] = 8'hA5;
    mem[16'h1235] = 8'h77;
    mem[16'h2000] = 8'h00;
    mem[16'h2001] = 8'hC3;
    RST_N    = 1'b0;
    SMP_A    = 16'h0000;
    SMP_DO   = 8'h00;
    SMP_WE_N = 1'b1;
    DSP_REQ  = 1'b0;
    DSP_A    = 16'h0000;
    DSP_DO   = 8'h00;
    DSP_WE_N = 1'b1;
    LD_HOLD  = 1'b0;
    LD_REQ   = 1'b0;
    LD_A     = 16'h0000;
    LD_DO    = 8'h00;
    LD_WE_N  = 1'b1;
    test_reset();
    test_rotation();
    test_smp_read();
    test_dsp_back_to_back();
    test_stall();
    test_loader_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
